// File: rtl/adder_table_loader.sv
// adder_table_loader: serial loader for the TCAM adder slice tables.
// Assembles, checks and commits 8 cell entries plus 128 sum entries.
module adder_table_loader #(
  parameter int ADD_DEPTH = 8,
  parameter int ADD_W     = 2,
  parameter int SUM_DEPTH = 128,
  parameter int SUM_W     = 5,
  parameter int CSUM_W    = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         abort,
  input  logic [CSUM_W-1:0]            exp_csum,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [SUM_W-1:0]             in_data,
  output logic [ADD_DEPTH*ADD_W-1:0]   data_add,
  output logic [SUM_DEPTH*SUM_W-1:0]   data,
  output logic                         write_en,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic                         table_valid
);

  localparam int CNT_W = $clog2(SUM_DEPTH);
  localparam int AI_W  = $clog2(ADD_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_ADD,
    S_LOAD_SUM,
    S_CHECK,
    S_COMMIT,
    S_FAIL
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CSUM_W-1:0] csum_q;
  logic [CSUM_W-1:0] exp_q;
  logic              fmt_q;
  logic              err_q;
  logic              tv_q;
  logic [ADD_W-1:0]  add_q [ADD_DEPTH];
  logic [SUM_W-1:0]  sum_q [SUM_DEPTH];

  logic loading;
  logic beat;
  logic last_add;
  logic last_sum;
  logic check_ok;
  logic go;

  assign loading  = (state_q == S_LOAD_ADD) || (state_q == S_LOAD_SUM);
  assign beat     = loading && in_valid && !abort;
  assign last_add = cnt_q == CNT_W'(ADD_DEPTH-1);
  assign last_sum = cnt_q == CNT_W'(SUM_DEPTH-1);
  assign check_ok = (csum_q == exp_q) && !fmt_q;
  assign go       = (state_q == S_IDLE) && start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LOAD_ADD;
      end
      S_LOAD_ADD: begin
        if (abort) state_d = S_IDLE;
        else if (beat && last_add) state_d = S_LOAD_SUM;
      end
      S_LOAD_SUM: begin
        if (abort) state_d = S_IDLE;
        else if (beat && last_sum) state_d = S_CHECK;
      end
      S_CHECK: begin
        state_d = check_ok ? S_COMMIT : S_FAIL;
      end
      S_COMMIT: state_d = S_IDLE;
      S_FAIL:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      csum_q <= '0;
      exp_q  <= '0;
      fmt_q  <= 1'b0;
      err_q  <= 1'b0;
      tv_q   <= 1'b0;
    end else begin
      if (go) begin
        exp_q  <= exp_csum;
        err_q  <= 1'b0;
        cnt_q  <= '0;
        csum_q <= '0;
        fmt_q  <= 1'b0;
      end
      if (beat) begin
        csum_q <= csum_q + CSUM_W'(in_data);
        if (state_q == S_LOAD_ADD) begin
          if (|in_data[SUM_W-1:ADD_W]) fmt_q <= 1'b1;
          cnt_q <= last_add ? '0 : cnt_q + 1'b1;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
      if (state_q == S_COMMIT) tv_q <= 1'b1;
      if (state_q == S_FAIL) err_q <= 1'b1;
    end
  end

  // Table storage is written only by accepted beats; no clear on start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ADD_DEPTH; i++) add_q[i] <= '0;
      for (int i = 0; i < SUM_DEPTH; i++) sum_q[i] <= '0;
    end else if (beat) begin
      if (state_q == S_LOAD_ADD) begin
        add_q[cnt_q[AI_W-1:0]] <= in_data[ADD_W-1:0];
      end else begin
        sum_q[cnt_q] <= in_data;
      end
    end
  end

  for (genvar i = 0; i < ADD_DEPTH; i++) begin : g_add
    assign data_add[i*ADD_W +: ADD_W] = add_q[i];
  end

  for (genvar i = 0; i < SUM_DEPTH; i++) begin : g_sum
    assign data[i*SUM_W +: SUM_W] = sum_q[i];
  end

  assign in_ready    = loading;
  assign busy        = state_q != S_IDLE;
  assign write_en    = state_q == S_COMMIT;
  assign done        = state_q == S_COMMIT;
  assign err         = err_q;
  assign table_valid = tv_q;

endmodule

// File: tb/tb_adder_table_loader.sv
// tb_adder_table_loader: beat-count model plus directed loads.
// Checks outputs every cycle and pins the model with literal values.
module tb_adder_table_loader;

  localparam int NB = 136;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [7:0]   exp_csum = 8'h00;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [4:0]   in_data = 5'h00;
  logic [15:0]  data_add;
  logic [639:0] data;
  logic         write_en;
  logic         busy;
  logic         done;
  logic         err;
  logic         table_valid;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int we_cnt = 0;
  int we_cyc = 0;
  bit chk_en = 0;

  logic [4:0] stim [NB];

  adder_table_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .exp_csum(exp_csum), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .data_add(data_add), .data(data),
    .write_en(write_en), .busy(busy), .done(done), .err(err),
    .table_valid(table_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Model: a load is "active" from start until two cycles after beat 136.
  bit         m_act, m_bad, m_tv, m_err;
  int         m_n, m_post, m_sum;
  logic [7:0] m_exp;
  logic [1:0] m_add [8];
  logic [4:0] m_tab [128];

  function automatic bit m_ok();
    return ((m_sum % 256) == int'(m_exp)) && !m_bad;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act = 0; m_n = 0; m_post = 0; m_sum = 0; m_bad = 0;
      m_exp = 8'h00; m_tv = 0; m_err = 0;
      foreach (m_add[i]) m_add[i] = 2'b00;
      foreach (m_tab[i]) m_tab[i] = 5'h00;
    end else if (!m_act) begin
      if (start) begin
        m_act = 1; m_n = 0; m_post = 0; m_sum = 0;
        m_bad = 0; m_exp = exp_csum; m_err = 0;
      end
    end else if (m_n < NB) begin
      if (abort) begin
        m_act = 0;
      end else if (in_valid) begin
        if (m_n < 8) begin
          m_add[m_n] = in_data[1:0];
          if (in_data > 5'd3) m_bad = 1;
        end else begin
          m_tab[m_n-8] = in_data;
        end
        m_sum += int'(in_data);
        m_n++;
      end
    end else begin
      m_post++;
      if (m_post == 2) begin
        m_act = 0;
        if (m_ok()) m_tv = 1;
        else m_err = 1;
      end
    end
  end

  task automatic chk(string nm, logic [639:0] act, logic [639:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, expv);
    end
  endtask

  always @(negedge clk) begin : cmp
    logic [15:0]  ea;
    logic [639:0] et;
    bit           e_we;
    if (write_en === 1'b1) begin
      we_cnt++;
      we_cyc = cyc;
    end
    if (chk_en) begin
      for (int i = 0; i < 8; i++) ea[i*2 +: 2] = m_add[i];
      for (int i = 0; i < 128; i++) et[i*5 +: 5] = m_tab[i];
      e_we = m_act && (m_n == NB) && (m_post == 1) && m_ok();
      chk("busy", busy, m_act);
      chk("in_ready", in_ready, m_act && (m_n < NB));
      chk("write_en", write_en, e_we);
      chk("done", done, e_we);
      chk("err", err, m_err);
      chk("table_valid", table_valid, m_tv);
      chk("data_add", data_add, ea);
      chk("data", data, et);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_const(input logic [4:0] v);
    foreach (stim[i]) stim[i] = v;
  endtask

  task automatic fill_fa();
    logic [2:0] k;
    logic [6:0] j;
    for (int i = 0; i < 8; i++) begin
      k = 3'(i);
      stim[i] = {3'b000,
                 (k[2] & k[1]) | (k[2] & k[0]) | (k[1] & k[0]),
                 k[2] ^ k[1] ^ k[0]};
    end
    for (int i = 0; i < 128; i++) begin
      j = 7'(i);
      stim[8+i] = 5'(j[6:3]) + 5'(j[2:0]);
    end
  endtask

  function automatic logic [7:0] csum();
    int s = 0;
    foreach (stim[i]) s += int'(stim[i]);
    return 8'(s);
  endfunction

  // lat = cycles from the start edge to the write_en cycle, -1 if none.
  task automatic load(input logic [7:0] e, input bit gap,
                      input int ab_at, input int rs_at, output int lat);
    int i, g, s, w0;
    bit ph;
    lat = -1;
    w0 = we_cnt;
    start = 1'b1;
    exp_csum = e;
    tick();
    s = cyc;
    start = 1'b0;
    i = 0; g = 0; ph = 0;
    while (i < NB && g < 1000) begin
      if (i == ab_at) begin
        abort = 1'b1; in_valid = 1'b1; in_data = stim[i];
        tick();
        abort = 1'b0; in_valid = 1'b0;
        return;
      end
      if (i == rs_at) begin
        in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        return;
      end
      in_valid = gap ? ph : 1'b1;
      in_data = stim[i];
      start = gap && (g % 7 == 2);
      tick();
      if (in_valid) i++;
      ph = ~ph;
      g++;
    end
    in_valid = 1'b0;
    start = 1'b0;
    if (g >= 1000) chk("beat_timeout", 1, 0);
    g = 0;
    while (busy && g < 20) begin
      tick();
      g++;
    end
    if (g >= 20) chk("busy_timeout", 1, 0);
    if (we_cnt != w0) lat = we_cyc - s;
  endtask

  initial begin
    int lat, w0;
    repeat (2) @(posedge clk);
    chk_en = 1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_data", data, 0);
    tick();
    rst_n = 1'b1;
    tick();

    fill_const(5'h00);
    w0 = we_cnt;
    load(8'h00, 0, -1, -1, lat);
    chk("t1_lat", lat, 137);
    chk("t1_we_count", we_cnt - w0, 1);
    chk("t1_tv", table_valid, 1);
    chk("t1_err", err, 0);
    chk("t1_data", data, 0);

    fill_const(5'h01);
    load(8'h88, 0, -1, -1, lat);
    chk("t2_lat", lat, 137);
    chk("t2_data_add", data_add, 16'h5555);
    chk("t2_data", data, {128{5'h01}});
    chk("t2_err", err, 0);

    w0 = we_cnt;
    load(8'h87, 0, -1, -1, lat);
    chk("t3_err", err, 1);
    chk("t3_we_count", we_cnt - w0, 0);
    chk("t3_tv", table_valid, 1);

    fill_fa();
    stim[5] = 5'h06;
    w0 = we_cnt;
    load(csum(), 0, -1, -1, lat);
    chk("t4_fmt_err", err, 1);
    chk("t4_fmt_we", we_cnt - w0, 0);
    fill_fa();
    w0 = we_cnt;
    load(csum(), 0, -1, -1, lat);
    chk("t4_ok_err", err, 0);
    chk("t4_ok_we", we_cnt - w0, 1);
    chk("t4_data_add", data_add, 16'hE994);

    w0 = we_cnt;
    load(csum(), 1, -1, -1, lat);
    chk("t5_lat_range", (lat >= 273) && (lat <= 275), 1);
    chk("t5_we_count", we_cnt - w0, 1);

    w0 = we_cnt;
    load(csum(), 0, 50, -1, lat);
    chk("t6_abort_busy", busy, 0);
    chk("t6_abort_ready", in_ready, 0);
    repeat (3) tick();
    chk("t6_abort_we", we_cnt - w0, 0);
    chk("t6_abort_tv", table_valid, 1);

    load(csum(), 0, -1, 100, lat);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_ready", in_ready, 0);
    chk("t6_rst_we", we_cnt - w0, 0);
    chk("t6_rst_tv", table_valid, 0);
    chk("t6_rst_data", data, 0);
    chk("t6_rst_data_add", data_add, 0);
    tick();

    fill_const(5'h01);
    load(8'h88, 0, -1, -1, lat);
    chk("t6_fresh_lat", lat, 137);
    chk("t6_fresh_tv", table_valid, 1);
    chk("t6_fresh_data", data, {128{5'h01}});

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/adder_table_loader.md
Name: adder_table_loader

Overview:
- Upstream programming stage for the TCAM-based 4-bit adder slices.
- Accepts a serial stream of 136 table entries over a valid/ready handshake: 8 full-adder cell entries, then 128 sum-table entries.
- Assembles the entries into the parallel data_add/data arrays and checks them with a format rule and a checksum.
- Issues a single-cycle write_en so the adder slice captures a verified table.

Parameters:
- ADD_DEPTH, 8, number of full-adder cell entries (data_add).
- ADD_W, 2, width of a cell entry: bit1 = carry, bit0 = sum.
- SUM_DEPTH, 128, number of sum-table entries (data).
- SUM_W, 5, width of a sum-table entry and of in_data.
- CSUM_W, 8, checksum width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a load; sampled only in IDLE.
- abort  in  1  cancel an in-progress load.
- exp_csum  in  CSUM_W  expected checksum; captured on an accepted start.
- in_valid  in  1  entry beat valid.
- in_ready  out  1  loader can accept a beat.
- in_data  in  SUM_W  entry payload.
- data_add  out  ADD_W x ADD_DEPTH  assembled cell table.
- data  out  SUM_W x SUM_DEPTH  assembled sum table.
- write_en  out  1  one-cycle commit pulse to the adder slice.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse, coincident with write_en.
- err  out  1  sticky failure flag; cleared on the next accepted start.
- table_valid  out  1  the adder slice holds a verified table.

Behaviour:
- Reset values: state IDLE; all outputs 0; both arrays all-zero; counter, checksum and format flag 0. Reset mid-load abandons the load immediately; no write_en.
- States: IDLE, LOAD_ADD, LOAD_SUM, CHECK, COMMIT, FAIL.
- Beat: a rising edge with in_valid && in_ready.
  - in_ready = 1 only in LOAD_ADD and LOAD_SUM.
  - in_valid while in_ready = 0 is ignored.
- IDLE:
  - start=1: capture exp_csum; clear err, counter, checksum and format flag; go to LOAD_ADD.
  - start outside IDLE is ignored.
- LOAD_ADD, on each beat:
  - data_add[cnt] <= in_data[1:0].
  - in_data[4:2] != 0 sets the sticky format flag.
  - checksum += zero-extended in_data, modulo 2^CSUM_W.
  - cnt==ADD_DEPTH-1: reset cnt to 0, go to LOAD_SUM. Otherwise cnt++.
- LOAD_SUM, on each beat:
  - data[cnt] <= in_data.
  - checksum accumulates the same way.
  - cnt==SUM_DEPTH-1: go to CHECK.
- CHECK, one cycle:
  - checksum==captured exp_csum and format flag clear: go to COMMIT.
  - Otherwise: go to FAIL.
- COMMIT, one cycle:
  - write_en=1, done=1; arrays are stable.
  - table_valid <= 1 at the exit edge; go to IDLE.
- FAIL, one cycle:
  - err <= 1; no write_en; table_valid unchanged; go to IDLE.
- abort=1 in LOAD_ADD or LOAD_SUM:
  - go to IDLE at the next edge; err and table_valid unchanged.
  - A beat presented in the same cycle is discarded.
  - abort in IDLE, CHECK, COMMIT or FAIL has no effect.
- Array outputs are registers updated only by beats. They keep partial contents after abort or FAIL; table_valid reflects only committed contents.
- Latency with in_valid held high: start sampled at edge N, beats at edges N+1..N+136, CHECK during the cycle after N+136, write_en high for the cycle after edge N+137. Backpressure-free; in_valid gaps only stretch the sequence.

Test Plan:
- Reset, then start with exp_csum=0x00 and 136 beats of in_data=0: write_en and done high exactly one cycle, 137 cycles after start; arrays all zero; table_valid=1; err=0.
- Start with exp_csum=0x88 and 136 beats of in_data=5'h01: commit; data_add all 2'b01; data all 5'h01; checksum 136=0x88 matches.
- Same stream with exp_csum=0x87: FAIL; err=1; no write_en; table_valid keeps its prior value.
- Correct full-adder table with data_add[5] beat sent as 5'h06: format flag set; err=1; no write_en. A following correct load clears err and commits.
- in_valid toggling 1/0 every cycle: only accepted beats counted; write_en arrives 1+2*136+1 cycles after start, ±1 cycle for gap phase. Start pulses during the load are ignored.
- abort at beat 50 and, separately, rst_n low at beat 100: busy drops; in_ready=0; no write_en. After reset, everything is zero; a fresh load then commits normally.
